baseline_ctrl: RTL and testbench

Sequencer for the baseline datapath. It counts incoming feature samples and emits the load strobes that push non-overlapping 1 s, 5 s and 30 s window sums into their shift-register stages. It tracks how many 30 s segments have been loaded and raises `baseline_valid` once the 4 min history is full. It can freeze baseline updates so seizure-period data is never absorbed into the baseline. It sits between the feature front-end and the baseline shift/add chain, and reports status to the top-level controller.

---
 rtl/baseline_ctrl.sv | 151 +++++++++++++++
 tb/tb_baseline_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/baseline_ctrl.sv
// rtl/baseline_ctrl.sv - window sequencer and load-strobe generator for the baseline datapath
// Optional freeze feature: define BASELINE_CTRL_FREEZE_EN to enable the FROZEN state.
module baseline_ctrl #(
   parameter int N0 = 5,
   parameter int N1 = 5,
   parameter int N2 = 6,
   parameter int N3 = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       sample_valid,
   input  logic                       freeze,
   output logic                       ld0,
   output logic                       ld1,
   output logic                       ld2,
   output logic [$clog2(N3+1)-1:0]    seg_count,
   output logic                       baseline_valid,
   output logic [1:0]                 state
);

   localparam int W0 = (N0 > 1) ? $clog2(N0) : 1;
   localparam int W1 = (N1 > 1) ? $clog2(N1) : 1;
   localparam int W2 = (N2 > 1) ? $clog2(N2) : 1;
   localparam int SW = $clog2(N3 + 1);

   localparam logic [W0-1:0] LAST0   = W0'(N0 - 1);
   localparam logic [W1-1:0] LAST1   = W1'(N1 - 1);
   localparam logic [W2-1:0] LAST2   = W2'(N2 - 1);
   localparam logic [SW-1:0] SEG_MAX = SW'(N3);
   localparam logic [SW-1:0] SEG_PRE = SW'(N3 - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      VALID  = 2'd2,
      FROZEN = 2'd3
   } state_t;

   state_t st;
   state_t st_nxt;

   logic [W0-1:0] c0;
   logic [W1-1:0] c1;
   logic [W2-1:0] c2;

   logic accept;
   logic clr;
   logic seg_hit;
   logic w0;
   logic w1;
   logic w2;
   logic freeze_eff;

   // Delay taps that stagger ld1/ld2 behind ld0 so each adder stage settles.
   logic p1;
   logic p2a;
   logic p2b;

`ifdef BASELINE_CTRL_FREEZE_EN
   assign freeze_eff = freeze;
`else
   logic unused_freeze;
   assign unused_freeze = freeze;
   assign freeze_eff    = 1'b0;
`endif

   assign state = st;

   always_comb begin
      st_nxt  = st;
      accept  = 1'b0;
      clr     = 1'b0;
      seg_hit = ld2 && (seg_count == SEG_PRE);
      case (st)
         IDLE: begin
            if (!en) st_nxt = FILL;
         end
         FILL: begin
            accept = sample_valid && !en;
            if (seg_hit) st_nxt = VALID;
         end
         VALID: begin
            // A freeze request outranks a coincident sample.
            if (freeze_eff) begin
               st_nxt = FROZEN;
               clr    = 1'b1;
            end else begin
               accept = sample_valid && !en;
            end
         end
         FROZEN: begin
            if (!freeze_eff) st_nxt = VALID;
         end
         default: st_nxt = IDLE;
      endcase
   end

   assign w0 = accept && (c0 == LAST0);
   assign w1 = w0 && (c1 == LAST1);
   assign w2 = w1 && (c2 == LAST2);

   always_ff @(posedge clk) begin
      if (rst) begin
         st <= IDLE;
      end else begin
         st <= st_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         c0 <= '0;
         c1 <= '0;
         c2 <= '0;
      end else if (accept) begin
         c0 <= w0 ? '0 : c0 + 1'b1;
         if (w0) c1 <= w1 ? '0 : c1 + 1'b1;
         if (w1) c2 <= w2 ? '0 : c2 + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ld0 <= 1'b0;
         p1  <= 1'b0;
         ld1 <= 1'b0;
         p2a <= 1'b0;
         p2b <= 1'b0;
         ld2 <= 1'b0;
      end else begin
         ld0 <= w0;
         p1  <= w1;
         ld1 <= p1;
         p2a <= w2;
         p2b <= p2a;
         ld2 <= p2b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_count      <= '0;
         baseline_valid <= 1'b0;
      end else begin
         if (ld2 && (seg_count != SEG_MAX)) seg_count <= seg_count + 1'b1;
         if (seg_hit) baseline_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_baseline_ctrl.sv
// tb/tb_baseline_ctrl.sv - self-checking bench for baseline_ctrl against a sample-count reference model
module tb_baseline_ctrl;

   localparam int N0 = 5;
   localparam int N1 = 5;
   localparam int N2 = 6;
   localparam int N3 = 8;
`ifdef BASELINE_CTRL_FREEZE_EN
   localparam bit FREEZE_EN = 1'b1;
`else
   localparam bit FREEZE_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       sample_valid;
   logic       freeze;
   logic       ld0;
   logic       ld1;
   logic       ld2;
   logic [3:0] seg_count;
   logic       baseline_valid;
   logic [1:0] state;

   always #5 clk = ~clk;

   baseline_ctrl #(.N0(N0), .N1(N1), .N2(N2), .N3(N3)) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .sample_valid   (sample_valid),
      .freeze         (freeze),
      .ld0            (ld0),
      .ld1            (ld1),
      .ld2            (ld2),
      .seg_count      (seg_count),
      .baseline_valid (baseline_valid),
      .state          (state)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: total accepted samples since last clear decides every window boundary.
   int m_state, m_acc, m_seg, cyc;
   bit m_bv, m_ld0, m_ld1, m_ld2;
   bit s1 [8];
   bit s2 [8];

   int cnt0, cnt1, cnt2;
   int last0, last1, last2, bv_cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit e, input bit sv, input bit fz);
      bit fz_eff, acc_ok, prev2, hit;
      if (r) begin
         m_state = 0; m_acc = 0; m_seg = 0; m_bv = 0;
         m_ld0 = 0; m_ld1 = 0; m_ld2 = 0;
         for (int i = 0; i < 8; i++) begin s1[i] = 0; s2[i] = 0; end
      end else begin
         fz_eff = FREEZE_EN ? fz : 1'b0;
         prev2  = m_ld2;
         acc_ok = sv && !e && (m_state == 1 || (m_state == 2 && !fz_eff));
         hit    = prev2 && (m_seg == N3 - 1);
         if (prev2 && m_seg < N3) m_seg++;
         if (hit) m_bv = 1;
         m_ld0 = 0;
         if (acc_ok) begin
            m_acc++;
            m_ld0 = (m_acc % N0 == 0);
            if (m_acc % (N0 * N1) == 0) s1[(cyc + 1) % 8] = 1;
            if (m_acc % (N0 * N1 * N2) == 0) s2[(cyc + 2) % 8] = 1;
         end
         m_ld1 = s1[cyc % 8]; s1[cyc % 8] = 0;
         m_ld2 = s2[cyc % 8]; s2[cyc % 8] = 0;
         case (m_state)
            0: if (!e) m_state = 1;
            1: if (hit) m_state = 2;
            2: if (fz_eff) begin m_state = 3; m_acc = 0; end
            3: if (!fz_eff) m_state = 2;
            default: m_state = 0;
         endcase
      end
      cyc++;
   endtask

   task automatic tick(input bit r, input bit e, input bit sv, input bit fz);
      rst = r; en = e; sample_valid = sv; freeze = fz;
      @(posedge clk);
      model_edge(r, e, sv, fz);
      #1;
      check("ld0", ld0, m_ld0);
      check("ld1", ld1, m_ld1);
      check("ld2", ld2, m_ld2);
      check("seg_count", seg_count, m_seg);
      check("baseline_valid", baseline_valid, m_bv);
      check("state", state, m_state);
      if (ld0 === 1'b1) begin cnt0++; last0 = cyc; end
      if (ld1 === 1'b1) begin cnt1++; last1 = cyc; end
      if (ld2 === 1'b1) begin cnt2++; last2 = cyc; end
      if (baseline_valid === 1'b1 && bv_cyc < 0) bv_cyc = cyc;
   endtask

   task automatic clear_counts();
      cnt0 = 0; cnt1 = 0; cnt2 = 0;
      last0 = -1; last1 = -1; last2 = -1; bv_cyc = -1;
   endtask

   initial begin
      int t, need, c0_before;
      cyc = 0;
      clear_counts();

      // reset state
      tick(1, 1, 0, 0);
      tick(1, 1, 0, 0);
      check("reset_state", state, 0);
      check("reset_seg", seg_count, 0);

      // strobe stagger from reset
      tick(0, 0, 0, 0);
      clear_counts();
      for (int i = 0; i < 150; i++) tick(0, 0, 1, 0);
      t = cyc - 1;
      for (int k = 0; k < 5; k++) begin
         tick(0, 0, 0, 0);
         if (k == 2) check("stagger_seg_t4", seg_count, 1);
      end
      check("stagger_ld0_t1", last0, t + 1);
      check("stagger_ld1_t2", last1, t + 2);
      check("stagger_ld2_t3", last2, t + 3);

      // enable gating mid-window
      tick(0, 0, 1, 0);
      tick(0, 0, 1, 0);
      c0_before = cnt0;
      for (int i = 0; i < 10; i++) tick(0, 1, 1, 0);
      check("gate_no_ld0", cnt0, c0_before);
      need = -1;
      for (int i = 0; i < 8; i++) begin
         tick(0, 0, 1, 0);
         if (ld0 === 1'b1 && need < 0) need = i + 1;
      end
      check("gate_samples_to_ld0", need, N0 - 2);

      // random traffic during fill
      for (int i = 0; i < 600; i++)
         tick(0, ($urandom_range(7) == 0), $urandom_range(1), $urandom_range(1));

      // fill to valid
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      clear_counts();
      t = 0;
      for (int i = 0; i < 1200; i++) begin
         tick(0, 0, 1, 0);
         t = cyc - 1;
         tick(0, 0, 0, 0);
      end
      for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
      check("fill_ld0_count", cnt0, 240);
      check("fill_ld1_count", cnt1, 48);
      check("fill_ld2_count", cnt2, 8);
      check("fill_seg", seg_count, 8);
      check("fill_bv_latency", bv_cyc, t + 4);
      check("fill_state", state, 2);

`ifdef BASELINE_CTRL_FREEZE_EN
      for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);
      tick(0, 0, 1, 1);
      check("freeze_state", state, 3);
      clear_counts();
      for (int i = 0; i < 20; i++) tick(0, 0, 1, 1);
      check("freeze_no_ld0", cnt0, 0);
      check("freeze_no_ld2", cnt2, 0);
      tick(0, 0, 0, 0);
      check("unfreeze_state", state, 2);
      need = -1;
      for (int i = 0; i < 8; i++) begin
         tick(0, 0, 1, 0);
         if (ld0 === 1'b1 && need < 0) need = i + 1;
      end
      check("unfreeze_samples_to_ld0", need, N0);
      check("freeze_bv_hold", baseline_valid, 1);
`else
      clear_counts();
      for (int i = 0; i < 5; i++) tick(0, 0, 1, 1);
      check("nofreeze_state", state, 2);
      check("nofreeze_ld0_count", cnt0, 1);
`endif

      // random traffic once valid, with freeze toggling
      for (int i = 0; i < 800; i++)
         tick(0, ($urandom_range(7) == 0), $urandom_range(1), ($urandom_range(5) == 0));

      // reset in the middle of the strobe pipeline
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      for (int i = 0; i < 150; i++) tick(0, 0, 1, 0);
      clear_counts();
      tick(1, 0, 0, 0);
      check("midrst_ld0", ld0, 0);
      check("midrst_ld1", ld1, 0);
      check("midrst_ld2", ld2, 0);
      check("midrst_seg", seg_count, 0);
      check("midrst_bv", baseline_valid, 0);
      check("midrst_state", state, 0);
      for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
      check("midrst_ld1_never", cnt1, 0);
      check("midrst_ld2_never", cnt2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
